// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if
// Bundles the pipeline-control signals exchanged between the ID stage /
// memory system (master side) and the ctrl_pipe stage-register block
// (slave side).
//
// Signals (direction as seen by the slave, ctrl_pipe):
//   in  id_valid, id_wb[1:0], id_m[2:0], id_ex[5:0], id_rs, id_rt, id_rd
//   in  stall_ext, flush_id
//   out ex_valid, ex_wb, ex_m, ex_ex, ex_rs, ex_rt, ex_wreg   (ID/EX)
//   out mem_valid, mem_wb, mem_m, mem_wreg                    (EX/MEM)
//   out wb_valid, wb_wb, wb_wreg                              (MEM/WB)
//   out fwd_a, fwd_b, hazard_stall, pc_write_en, ifid_write_en
interface ctrl_pipe_if;
    // ID-stage instruction and pipeline control requests
    logic       id_valid;
    logic [1:0] id_wb;       // {RegWrite, MemtoReg}
    logic [2:0] id_m;        // {Branch, MemRead, MemWrite}
    logic [5:0] id_ex;       // {RegDst, ALUSrc, ALUControl[3:0]}
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       stall_ext;
    logic       flush_id;

    // ID/EX register
    logic       ex_valid;
    logic [1:0] ex_wb;
    logic [2:0] ex_m;
    logic [5:0] ex_ex;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_wreg;

    // EX/MEM register
    logic       mem_valid;
    logic [1:0] mem_wb;
    logic [2:0] mem_m;
    logic [4:0] mem_wreg;

    // MEM/WB register
    logic       wb_valid;
    logic [1:0] wb_wb;
    logic [4:0] wb_wreg;

    // Hazard / forwarding
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       hazard_stall;
    logic       pc_write_en;
    logic       ifid_write_en;

    modport slave (
        input  id_valid, id_wb, id_m, id_ex, id_rs, id_rt, id_rd,
        input  stall_ext, flush_id,
        output ex_valid, ex_wb, ex_m, ex_ex, ex_rs, ex_rt, ex_wreg,
        output mem_valid, mem_wb, mem_m, mem_wreg,
        output wb_valid, wb_wb, wb_wreg,
        output fwd_a, fwd_b, hazard_stall, pc_write_en, ifid_write_en
    );

    modport master (
        output id_valid, id_wb, id_m, id_ex, id_rs, id_rt, id_rd,
        output stall_ext, flush_id,
        input  ex_valid, ex_wb, ex_m, ex_ex, ex_rs, ex_rt, ex_wreg,
        input  mem_valid, mem_wb, mem_m, mem_wreg,
        input  wb_valid, wb_wb, wb_wreg,
        input  fwd_a, fwd_b, hazard_stall, pc_write_en, ifid_write_en
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
// Control half of a classic 5-stage pipeline: the ID/EX, EX/MEM and MEM/WB
// control/register-field registers, the hazard (stall) detector and the
// ALU operand forwarding selects.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    ctrl_pipe_if.slave  ID inputs, stage registers, hazard/forward
//
// Build option:
//   CTRL_PIPE_FWD_UNIT_EN  defined   -> forwarding unit present; only a
//                                       load in EX followed by a dependent
//                                       instruction stalls (1 bubble).
//                          undefined -> no forwarding (fwd_a/fwd_b = 00);
//                                       any in-flight writer in EX or MEM
//                                       that a new instruction reads stalls
//                                       (up to 2 bubbles).
module ctrl_pipe (
    input  logic          clk,
    input  logic          rst_n,
    ctrl_pipe_if.slave    bus
);

    // ID/EX
    logic       r_ex_valid;
    logic [1:0] r_ex_wb;
    logic [2:0] r_ex_m;
    logic [5:0] r_ex_ex;
    logic [4:0] r_ex_rs;
    logic [4:0] r_ex_rt;
    logic [4:0] r_ex_wreg;

    // EX/MEM
    logic       r_mem_valid;
    logic [1:0] r_mem_wb;
    logic [2:0] r_mem_m;
    logic [4:0] r_mem_wreg;

    // MEM/WB
    logic       r_wb_valid;
    logic [1:0] r_wb_wb;
    logic [4:0] r_wb_wreg;

    logic [4:0] w_id_wreg;
    logic       w_hazard;
    logic       w_ex_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A stage only counts as a writer of r when it holds a real instruction
    // that writes the register file, and never for $0 (hard-wired zero).
    function automatic logic f_writes(
        input logic       valid,
        input logic       reg_write,
        input logic [4:0] wreg,
        input logic [4:0] r
    );
        return valid & reg_write & (wreg != 5'd0) & (wreg == r);
    endfunction

    // RegDst selects rd (R-type) over rt (I-type) as the destination.
    assign w_id_wreg = bus.id_ex[5] ? bus.id_rd : bus.id_rt;

    logic w_ex_wr_rs;
    logic w_ex_wr_rt;
    assign w_ex_wr_rs = f_writes(r_ex_valid, r_ex_wb[1], r_ex_wreg, bus.id_rs);
    assign w_ex_wr_rt = f_writes(r_ex_valid, r_ex_wb[1], r_ex_wreg, bus.id_rt);

`ifdef CTRL_PIPE_FWD_UNIT_EN
    // Only a load's data arrives too late for forwarding to cover.
    assign w_hazard = bus.id_valid & ~bus.flush_id & r_ex_m[1]
                    & (w_ex_wr_rs | w_ex_wr_rt);

    // MEM has the younger result, so it wins over WB.
    always_comb begin
        w_fwd_a = 2'b00;
        if (f_writes(r_mem_valid, r_mem_wb[1], r_mem_wreg, r_ex_rs)) begin
            w_fwd_a = 2'b10;
        end else if (f_writes(r_wb_valid, r_wb_wb[1], r_wb_wreg, r_ex_rs)) begin
            w_fwd_a = 2'b01;
        end
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (f_writes(r_mem_valid, r_mem_wb[1], r_mem_wreg, r_ex_rt)) begin
            w_fwd_b = 2'b10;
        end else if (f_writes(r_wb_valid, r_wb_wb[1], r_wb_wreg, r_ex_rt)) begin
            w_fwd_b = 2'b01;
        end
    end
`else
    // Without forwarding the consumer waits until the producer reaches WB,
    // where the register file is written before it is read.
    logic w_mem_wr_rs;
    logic w_mem_wr_rt;
    assign w_mem_wr_rs = f_writes(r_mem_valid, r_mem_wb[1], r_mem_wreg, bus.id_rs);
    assign w_mem_wr_rt = f_writes(r_mem_valid, r_mem_wb[1], r_mem_wreg, bus.id_rt);

    assign w_hazard = bus.id_valid & ~bus.flush_id
                    & (w_ex_wr_rs | w_ex_wr_rt | w_mem_wr_rs | w_mem_wr_rt);

    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;
`endif

    // flush_id is already folded into w_hazard; both insert a bubble.
    assign w_ex_bubble = bus.flush_id | w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_wb     <= 2'b00;
            r_ex_m      <= 3'b000;
            r_ex_ex     <= 6'b000000;
            r_ex_rs     <= 5'd0;
            r_ex_rt     <= 5'd0;
            r_ex_wreg   <= 5'd0;
            r_mem_valid <= 1'b0;
            r_mem_wb    <= 2'b00;
            r_mem_m     <= 3'b000;
            r_mem_wreg  <= 5'd0;
            r_wb_valid  <= 1'b0;
            r_wb_wb     <= 2'b00;
            r_wb_wreg   <= 5'd0;
        end else if (!bus.stall_ext) begin
            // Downstream stages always advance so the pipe drains ahead
            // of any bubble inserted into ID/EX.
            r_mem_valid <= r_ex_valid;
            r_mem_wb    <= r_ex_wb;
            r_mem_m     <= r_ex_m;
            r_mem_wreg  <= r_ex_wreg;
            r_wb_valid  <= r_mem_valid;
            r_wb_wb     <= r_mem_wb;
            r_wb_wreg   <= r_mem_wreg;

            if (w_ex_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_wb    <= 2'b00;
                r_ex_m     <= 3'b000;
                r_ex_ex    <= 6'b000000;
                r_ex_rs    <= 5'd0;
                r_ex_rt    <= 5'd0;
                r_ex_wreg  <= 5'd0;
            end else begin
                r_ex_valid <= bus.id_valid;
                r_ex_wb    <= bus.id_wb;
                r_ex_m     <= bus.id_m;
                r_ex_ex    <= bus.id_ex;
                r_ex_rs    <= bus.id_rs;
                r_ex_rt    <= bus.id_rt;
                r_ex_wreg  <= w_id_wreg;
            end
        end
    end

    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_wb         = r_ex_wb;
    assign bus.ex_m          = r_ex_m;
    assign bus.ex_ex         = r_ex_ex;
    assign bus.ex_rs         = r_ex_rs;
    assign bus.ex_rt         = r_ex_rt;
    assign bus.ex_wreg       = r_ex_wreg;
    assign bus.mem_valid     = r_mem_valid;
    assign bus.mem_wb        = r_mem_wb;
    assign bus.mem_m         = r_mem_m;
    assign bus.mem_wreg      = r_mem_wreg;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_wb         = r_wb_wb;
    assign bus.wb_wreg       = r_wb_wreg;
    assign bus.fwd_a         = w_fwd_a;
    assign bus.fwd_b         = w_fwd_b;
    assign bus.hazard_stall  = w_hazard;
    assign bus.pc_write_en   = ~(bus.stall_ext | w_hazard);
    assign bus.ifid_write_en = ~(bus.stall_ext | w_hazard);

endmodule
